// File: rtl/bus_capture_fifo_pkg.sv
// Shared types and widths for the bus capture FIFO.
// Each buffered entry is the 8-bit sequence tag followed by the captured bus word.
package bus_capture_pkg;

    localparam int DATA_W      = 32;
    localparam int SEQ_W       = 8;
    localparam int MATCH_CNT_W = 16;

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [DATA_W-1:0] data;
    } capture_entry_t;

endpackage

// File: rtl/bus_capture_fifo_if.sv
// Handshake bundle for the capture FIFO: upstream push port, downstream pop port and status.
// The master side drives requests; the slave side is the FIFO itself.
interface bus_capture_fifo_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    import bus_capture_pkg::*;

    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_W-1:0]        in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic [SEQ_W-1:0]         out_seq;
    logic [$clog2(DEPTH):0]   count;
    logic [MATCH_CNT_W-1:0]   match_cnt;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_seq, count, match_cnt
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_seq, count, match_cnt
    );

endinterface

// File: rtl/bus_capture_fifo_ram.sv
// Entry storage for the capture FIFO: synchronous write, asynchronous read.
// Contents are never reset; occupancy tracking lives in the top level.
module bus_capture_ram #(
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH),
    parameter int ENTRY_W = $bits(bus_capture_pkg::capture_entry_t)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bus_capture_fifo.sv
// Capture FIFO: tags accepted bus words with a rolling sequence number, buffers them,
// and keeps a saturating count of words equal to MATCH_VAL.
module bus_capture_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int MATCH_VAL = 42
) (
    input  logic               clk,
    input  logic               rst,
    bus_capture_fifo_if.slave  bus
);
    import bus_capture_pkg::*;

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = SEQ_W + DATA_W;

    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [SEQ_W-1:0]       r_seq;
    logic [MATCH_CNT_W-1:0] r_match_cnt;

    logic                   w_full;
    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_match;
    logic [ENTRY_W-1:0]     w_wr_entry;
    logic [ENTRY_W-1:0]     w_rd_entry;

    function automatic logic [MATCH_CNT_W-1:0] sat_inc(input logic [MATCH_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // in_ready ignores out_ready, so a full FIFO never accepts even when popping.
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_in_ready  = !w_full && !bus.flush && !rst;
    assign w_out_valid = (r_count != '0) && !rst;
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready && !bus.flush;
    assign w_match     = (bus.in_data == DATA_W'(MATCH_VAL));
    assign w_wr_entry  = {r_seq, bus.in_data};

    bus_capture_ram #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .ENTRY_W (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_seq       <= '0;
            r_match_cnt <= '0;
        end else if (bus.flush) begin
            // seq and match_cnt deliberately survive a flush
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_seq    <= r_seq + 1'b1;
                if (w_match) begin
                    r_match_cnt <= sat_inc(r_match_cnt);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Every output reads as zero while reset is asserted.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = rst ? '0 : w_rd_entry[DATA_W-1:0];
    assign bus.out_seq   = rst ? '0 : w_rd_entry[ENTRY_W-1:DATA_W];
    assign bus.count     = rst ? '0 : r_count;
    assign bus.match_cnt = rst ? '0 : r_match_cnt;

endmodule
